// File: rtl/seg7_pkg.sv
// seg7_pkg: definitions shared by the 7-segment encoder and the scan-capture block.
//
// Contents:
//   SEG_A..SEG_G   bit positions of each segment inside a 7-bit code (bit6=a ... bit0=g)
//   SEG_0..SEG_9   active-high segment patterns for the decimal digits
//   SEG_BLANK      all segments off
//   BCD_BLANK      BCD value used to represent a blank digit
//   CNT_W          width of the stability counter (covers STABLE_CYCLES up to 15)
//   state_e        capture FSM states
package seg7_pkg;

  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  localparam int unsigned CNT_W = 4;

  // TRACK: waiting for a code to become stable. DWELL: code accepted, waiting for it to change.
  typedef enum logic {
    StTrack = 1'b0,
    StDwell = 1'b1
  } state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd: purely combinational 7-segment to BCD decoder.
//
// Ports:
//   seg   in  [6:0]  active-high segment pattern, bit6=a ... bit0=g
//   bcd   out [3:0]  decoded digit (0 when the pattern is illegal)
//   legal out        pattern is one of the accepted codes
//
// Build option: SEG7_BLANK_ACCEPT_EN -- when defined, the all-off pattern is accepted and
// decodes to BCD_BLANK; otherwise it is illegal like any other unknown pattern.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       legal
);

  always_comb begin
    bcd   = 4'h0;
    legal = 1'b0;
    unique case (seg)
      SEG_0: begin bcd = 4'd0; legal = 1'b1; end
      SEG_1: begin bcd = 4'd1; legal = 1'b1; end
      SEG_2: begin bcd = 4'd2; legal = 1'b1; end
      SEG_3: begin bcd = 4'd3; legal = 1'b1; end
      SEG_4: begin bcd = 4'd4; legal = 1'b1; end
      SEG_5: begin bcd = 4'd5; legal = 1'b1; end
      SEG_6: begin bcd = 4'd6; legal = 1'b1; end
      SEG_7: begin bcd = 4'd7; legal = 1'b1; end
      SEG_8: begin bcd = 4'd8; legal = 1'b1; end
      SEG_9: begin bcd = 4'd9; legal = 1'b1; end
`ifdef SEG7_BLANK_ACCEPT_EN
      SEG_BLANK: begin bcd = BCD_BLANK; legal = 1'b1; end
`endif
      default: begin bcd = 4'h0; legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: reads a multiplexed 7-segment display bus back into BCD frames.
//
// Each (segment code, digit select) sample must repeat STABLE_CYCLES times with a one-hot
// select before it is acted on, once per dwell. Legal codes fill the slot of the selected
// digit; illegal codes pulse code_err. When every digit slot has been written, the whole
// frame is published on bcd_out in one update together with a frame_valid pulse.
//
// Parameters:
//   DIGITS         number of multiplexed digits (1..8)
//   STABLE_CYCLES  identical samples required before a code is accepted (2..15)
//
// Ports:
//   clk          in               system clock, rising edge
//   rst          in               asynchronous active-high reset
//   seg_in       in  [6:0]        segment pattern, bit6=a ... bit0=g
//   dig_sel      in  [DIGITS-1:0] digit enable, expected one-hot
//   bcd_out      out [4*DIGITS-1:0] last complete frame, digit i at [4i+3:4i]
//   frame_valid  out              one-cycle pulse when bcd_out takes a new frame
//   code_err     out              one-cycle pulse on a stable illegal pattern
//   err_digit    out [2:0]        digit index of the most recent code_err
//
// Build option: SEG7_BLANK_ACCEPT_EN (see seg7_to_bcd) makes the blank pattern a legal code.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  frame_valid,
  output logic                  code_err,
  output logic [2:0]            err_digit
);

  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

  // Input stage and previous-sample history.
  logic [6:0]          seg_q, seg_prev_q;
  logic [DIGITS-1:0]   sel_q, sel_prev_q;

  // Stability tracking.
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sel_onehot;
  logic                sample_same;

  // FSM.
  state_e              state_q, state_d;
  logic                act;
  logic                wr_en;
  logic                err_en;

  // Decoder results for the counted sample.
  logic [3:0]          dec_bcd;
  logic                dec_legal;
  logic [2:0]          sel_idx;

  // Frame assembly and outputs.
  logic [4*DIGITS-1:0] slot_q, slot_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                fv_q, fv_d;
  logic                cerr_q, cerr_d;
  logic [2:0]          edig_q, edig_d;

  // ---------------------------------------------------------------------------------------
  // Input registers
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q      <= '0;
      sel_q      <= '0;
      seg_prev_q <= '0;
      sel_prev_q <= '0;
    end else begin
      seg_q      <= seg_in;
      sel_q      <= dig_sel;
      seg_prev_q <= seg_q;
      sel_prev_q <= sel_q;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Stability counter. After an update, cnt_q is the length of the run of identical one-hot
  // samples ending with the sample now held in seg_prev_q/sel_prev_q.
  // ---------------------------------------------------------------------------------------
  always_comb begin
    sel_onehot  = (sel_q != '0) && ((sel_q & (sel_q - DIGITS'(1))) == '0);
    sample_same = (seg_q == seg_prev_q) && (sel_q == sel_prev_q);
    if (!sample_same || !sel_onehot) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q >= STABLE) begin
      cnt_d = STABLE;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // FSM: state register, next state, outputs
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StTrack;
    end else begin
      state_q <= state_d;
    end
  end

  // The counter saturates while the sample holds, so leaving saturation means it changed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StTrack: if (cnt_q == STABLE) state_d = StDwell;
      StDwell: if (cnt_q != STABLE) state_d = StTrack;
    endcase
  end

  // Act only on the TRACK->DWELL transition so each dwell is handled exactly once.
  always_comb begin
    act    = (state_q == StTrack) && (cnt_q == STABLE);
    wr_en  = act && dec_legal;
    err_en = act && !dec_legal;
  end

  // ---------------------------------------------------------------------------------------
  // Decode of the counted sample
  // ---------------------------------------------------------------------------------------
  seg7_to_bcd u_dec (
    .seg   (seg_prev_q),
    .bcd   (dec_bcd),
    .legal (dec_legal)
  );

  always_comb begin
    sel_idx = 3'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (sel_prev_q[i]) sel_idx = 3'(i);
    end
  end

  // ---------------------------------------------------------------------------------------
  // Slots, mask and output registers. Completion looks at the registered mask, so it can
  // never coincide with a slot write: the FSM is in DWELL on the cycle after any write.
  // ---------------------------------------------------------------------------------------
  always_comb begin
    slot_d = slot_q;
    mask_d = mask_q;
    bcd_d  = bcd_q;
    fv_d   = 1'b0;
    cerr_d = 1'b0;
    edig_d = edig_q;

    if (mask_q == '1) begin
      bcd_d  = slot_q;
      fv_d   = 1'b1;
      mask_d = '0;
    end else if (wr_en) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (sel_prev_q[i]) slot_d[4*i +: 4] = dec_bcd;
      end
      mask_d = mask_q | sel_prev_q;
    end

    if (err_en) begin
      cerr_d = 1'b1;
      edig_d = sel_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
      mask_q <= '0;
      bcd_q  <= '0;
      fv_q   <= 1'b0;
      cerr_q <= 1'b0;
      edig_q <= 3'd0;
    end else begin
      slot_q <= slot_d;
      mask_q <= mask_d;
      bcd_q  <= bcd_d;
      fv_q   <= fv_d;
      cerr_q <= cerr_d;
      edig_q <= edig_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign frame_valid = fv_q;
  assign code_err    = cerr_q;
  assign err_digit   = edig_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture. A run-length reference model turns each driven cycle into
// capture/error events and queues the expected frame_valid / code_err responses; a monitor
// on the falling edge pops and compares them, and checks that outputs hold in between.
module tb_seg7_scan_capture;

  localparam int unsigned D = 4;
  localparam int unsigned S = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [6:0]     seg_in;
  logic [D-1:0]   dig_sel;
  logic [4*D-1:0] bcd_out;
  logic           frame_valid;
  logic           code_err;
  logic [2:0]     err_digit;

  always #5 clk = ~clk;

  seg7_scan_capture #(
    .DIGITS        (D),
    .STABLE_CYCLES (S)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .bcd_out     (bcd_out),
    .frame_valid (frame_valid),
    .code_err    (code_err),
    .err_digit   (err_digit)
  );

  typedef struct {
    bit             is_frame;
    logic [4*D-1:0] val;
    logic [2:0]     dig;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // Digit patterns a..g, written out from the display code table.
  logic [6:0] code_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  // Reference model state.
  logic [6:0]   m_seg;
  logic [D-1:0] m_sel;
  int           m_run;
  logic [3:0]   m_slot [D];
  logic [D-1:0] m_mask;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic m_decode(input logic [6:0] s, output bit ok, output logic [3:0] v);
    ok = 1'b0;
    v  = 4'h0;
    for (int i = 0; i < 10; i++) begin
      if (s == code_tab[i]) begin
        ok = 1'b1;
        v  = 4'(i);
      end
    end
`ifdef SEG7_BLANK_ACCEPT_EN
    if (s == 7'b0000000) begin
      ok = 1'b1;
      v  = 4'hF;
    end
`endif
  endtask

  task automatic model_reset();
    m_seg  = '0;
    m_sel  = '0;
    m_run  = 0;
    m_mask = '0;
    for (int i = 0; i < D; i++) m_slot[i] = 4'h0;
  endtask

  // One driven cycle: a dwell is acted on when a run of identical one-hot samples reaches S.
  task automatic model_step(input logic [6:0] s, input logic [D-1:0] d);
    bit         ok;
    logic [3:0] v;
    int         idx;
    exp_t       e;
    if ($countones(d) != 1) m_run = 0;
    else if (s == m_seg && d == m_sel) m_run++;
    else m_run = 1;
    m_seg = s;
    m_sel = d;
    if (m_run == S) begin
      idx = 0;
      for (int i = 0; i < D; i++) if (d[i]) idx = i;
      m_decode(s, ok, v);
      if (ok) begin
        m_slot[idx] = v;
        m_mask[idx] = 1'b1;
        if (m_mask == '1) begin
          e.is_frame = 1'b1;
          e.dig      = 3'd0;
          for (int i = 0; i < D; i++) e.val[4*i +: 4] = m_slot[i];
          expq.push_back(e);
          m_mask = '0;
        end
      end else begin
        e.is_frame = 1'b0;
        e.val      = '0;
        e.dig      = 3'(idx);
        expq.push_back(e);
      end
    end
  endtask

  task automatic hold(input logic [6:0] s, input logic [D-1:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      seg_in  = s;
      dig_sel = d;
      model_step(s, d);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    seg_in  = '0;
    dig_sel = '0;
    rst     = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk("reset_bcd_out", 32'(bcd_out), 32'h0);
    rst = 1'b0;
  endtask

  // Monitor: compares DUT responses with the queue and checks held values in between.
  logic [4*D-1:0] held_bcd = '0;
  logic [2:0]     held_dig = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held_bcd = '0;
      held_dig = '0;
      chk("rst_bcd_out", 32'(bcd_out), 32'h0);
      chk("rst_frame_valid", 32'(frame_valid), 32'h0);
      chk("rst_code_err", 32'(code_err), 32'h0);
      chk("rst_err_digit", 32'(err_digit), 32'h0);
    end else begin
      if (frame_valid) begin
        if (expq.size() == 0 || !expq[0].is_frame) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: bcd_out=%0h, no frame expected (t=%0t)",
                   bcd_out, $time);
        end else begin
          e = expq.pop_front();
          chk("frame_bcd_out", 32'(bcd_out), 32'(e.val));
          held_bcd = e.val;
        end
      end else begin
        chk("bcd_out_hold", 32'(bcd_out), 32'(held_bcd));
      end
      if (code_err) begin
        if (expq.size() == 0 || expq[0].is_frame) begin
          checks++;
          errors++;
          $display("FAIL unexpected_code_err: err_digit=%0d, no error expected (t=%0t)",
                   err_digit, $time);
        end else begin
          e = expq.pop_front();
          chk("code_err_digit", 32'(err_digit), 32'(e.dig));
          held_dig = e.dig;
        end
      end else begin
        chk("err_digit_hold", 32'(err_digit), 32'(held_dig));
      end
    end
  end

  initial begin
    logic [6:0]   rs;
    logic [D-1:0] rd;
    int           r;

    rst     = 1'b1;
    seg_in  = '0;
    dig_sel = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_bcd_out", 32'(bcd_out), 32'h0);
    chk("init_err_digit", 32'(err_digit), 32'h0);
    rst = 1'b0;

    // Frame capture 4,3,2,1 -> 16'h4321.
    hold(7'b0110000, 4'b0001, 6);
    hold(7'b1101101, 4'b0010, 6);
    hold(7'b1111001, 4'b0100, 6);
    hold(7'b0110011, 4'b1000, 6);
    hold(7'b0000000, 4'b0000, 4);
    chk("frame_4321", 32'(bcd_out), 32'h4321);

    // Glitches shorter than S.
    hold(7'b1111110, 4'b0001, 3);
    hold(7'b0110000, 4'b0001, 2);
    hold(7'b0000000, 4'b0000, 4);

    // Illegal code on digit 2.
    hold(7'b1000000, 4'b0100, 8);
    hold(7'b0000000, 4'b0000, 4);
    chk("illegal_err_digit", 32'(err_digit), 32'd2);

    // Non-one-hot select.
    hold(7'b1111111, 4'b0011, 10);
    hold(7'b0000000, 4'b0000, 4);

    // Partial frame then reset, then a full 9999 frame.
    hold(7'b1011011, 4'b0001, 6);
    hold(7'b1011111, 4'b0010, 6);
    hold(7'b1110000, 4'b0100, 6);
    hold(7'b0000000, 4'b0000, 4);
    do_reset();
    hold(7'b1111011, 4'b0001, 6);
    hold(7'b1111011, 4'b0010, 6);
    hold(7'b1111011, 4'b0100, 6);
    hold(7'b1111011, 4'b1000, 6);
    hold(7'b0000000, 4'b0000, 4);
    chk("frame_9999", 32'(bcd_out), 32'h9999);

    // Blank on digit 3, then digits 0..2.
    hold(7'b0000000, 4'b1000, 6);
    hold(7'b0000000, 4'b0000, 4);
`ifndef SEG7_BLANK_ACCEPT_EN
    chk("blank_err_digit", 32'(err_digit), 32'd3);
`endif
    hold(7'b0110000, 4'b0001, 6);
    hold(7'b1101101, 4'b0010, 6);
    hold(7'b1111001, 4'b0100, 6);
    hold(7'b0000000, 4'b0000, 4);
`ifdef SEG7_BLANK_ACCEPT_EN
    chk("frame_f321", 32'(bcd_out), 32'hF321);
`else
    hold(7'b0110011, 4'b1000, 6);
    hold(7'b0000000, 4'b0000, 4);
    chk("frame_4321_after_blank", 32'(bcd_out), 32'h4321);
`endif

    // Randomized dwells: mostly one-hot legal codes, some blanks, junk and bad selects.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 8) rd = D'(1) << $urandom_range(0, D - 1);
      else rd = D'($urandom_range(0, (1 << D) - 1));
      r = $urandom_range(0, 9);
      if (r < 7) rs = code_tab[$urandom_range(0, 9)];
      else if (r == 7) rs = 7'b0000000;
      else rs = 7'($urandom);
      hold(rs, rd, $urandom_range(1, 8));
    end
    hold(7'b0000000, 4'b0000, 8);
    chk("expect_queue_empty", 32'(expq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receive-side counterpart of the BCD-to-7-segment encoder.
- Watches a multiplexed multi-digit 7-segment bus (segment code plus one-hot digit select) and qualifies each code by stability.
- Maps each stable code back to a BCD digit and assembles a complete frame.
- Used for self-checking display paths and for reading the display drive back into logic.

Parameters:
- DIGITS, 4, number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 4, consecutive identical samples required before a code is accepted (2..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- seg_in  input  7  segment pattern, active-high; bit6=a, bit5=b ... bit0=g.
- dig_sel  input  DIGITS  digit enable, active-high, expected one-hot.
- bcd_out  output  4*DIGITS  assembled frame; digit i occupies bits [4i+3:4i].
- frame_valid  output  1  one-cycle pulse; bcd_out holds a new complete frame.
- code_err  output  1  one-cycle pulse; a stable but illegal pattern was seen.
- err_digit  output  3  index of the digit for the last code_err; holds its value until the next error.

Behaviour:
- Reset: all registers clear asynchronously. After reset, bcd_out=0, frame_valid=0, code_err=0, err_digit=0, captured mask=0, stability counter=0, state=TRACK.
- Input stage: seg_in and dig_sel are registered once on every clk. Only these sampled values are used below.
- Stability counter:
  - Reload to 1 when the sample differs from the previous sample, or when dig_sel is not one-hot (zero or multiple bits set).
  - Otherwise increment, saturating at STABLE_CYCLES.
- States:
  - TRACK: when the counter reaches STABLE_CYCLES, go to DWELL.
  - DWELL: acting on the current dwell exactly once, on the transition cycle.
    - If the code is legal: write its BCD to the slot for the selected digit and set that bit in the captured mask.
    - If the code is illegal: pulse code_err, load err_digit, leave the slot unwritten.
    - Any change of sample returns the block to TRACK.
- Legal codes are exactly the ten patterns: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011. Every other pattern is illegal.
- Rewriting a slot already in the captured mask overwrites its pending value. The mask bit stays set.
- Frame completion: when the mask becomes all ones, then on the next cycle:
  - the pending slots transfer to bcd_out in one update (all digits change together);
  - frame_valid pulses high for that cycle;
  - the mask clears.
  bcd_out holds its value between frames.
- Latency: input edge to slot write is 1 + STABLE_CYCLES cycles. Last slot write to frame_valid is 1 cycle.
- A capture and a frame completion on the same cycle are impossible by construction, because completion is evaluated on the registered mask.
- Reset mid-frame discards all partial slots. No frame_valid is produced for a partial frame.
- Glitches shorter than STABLE_CYCLES never write a slot and never raise code_err.

Optional Feature:
- Macro: SEG7_BLANK_ACCEPT_EN.
- Defined: the all-zero pattern with a valid one-hot select is legal. It decodes to 4'hF (blank) and sets the mask bit.
- Undefined: the all-zero pattern is illegal and raises code_err like any other illegal pattern.

Decomposition:
- Shared package seg7_pkg holds:
  - segment-code constants SEG_0..SEG_9 and SEG_BLANK;
  - the bit-order localparams;
  - the BCD_BLANK constant 4'hF.
  The encoder and this block both use it.
- Sub-module seg7_to_bcd: purely combinational; seg[6:0] in, bcd[3:0] and legal out; contains the SEG7_BLANK_ACCEPT_EN branch.
- The top level keeps the input registers, the stability counter, the FSM, the slot registers, the mask and the output registers.

Test Plan:
- Frame capture: hold dig_sel=0001 with seg_in=0110000, then 0010/1101101, then 0100/1111001, then 1000/0110011, each for 6 cycles. Expect one frame_valid pulse and bcd_out=16'h4321; no code_err.
- Glitch rejection: on digit0, hold 1111110 for 3 cycles then 0110000 for 2 cycles (STABLE_CYCLES=4). Expect no slot write, no code_err, mask unchanged.
- Illegal code: hold dig_sel=0100 with seg_in=1000000 for 8 cycles. Expect exactly one code_err pulse, err_digit=2, mask bit2 still 0.
- Non-one-hot select: hold dig_sel=0011 with seg_in=1111111 for 10 cycles. Expect no capture and no error.
- Reset mid-frame: capture digits 0–2, assert rst for 1 cycle, then capture all 4 digits as 9,9,9,9. Expect bcd_out=0 through the reset, then one frame_valid with bcd_out=16'h9999.
- Blank: seg_in=0000000 on digit3 for 6 cycles. With SEG7_BLANK_ACCEPT_EN defined, mask bit3 is set and the slot holds 4'hF. With it undefined, code_err pulses with err_digit=3.
